sram_burst_reader: RTL

//   Read-side client for the dual-port SRAM (DUALPORT_SRAM_SYN).
//   - Accepts a burst command (start address, word count).
//   - Drives the SRAM chip-select, read-address and read-enable pins.
//   - Captures read data and returns it through a small FIFO as a valid/ready stream.
//   - Sits between a DMA/consumer and the SRAM read port; the write side is driven elsewhere.

---
 rtl/sram_burst_reader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sram_burst_reader.sv
// Read-side burst client for the dual-port SRAM: issues reads, buffers words in a FIFO, streams them out.
// Build option SRAM_RD_WRAP_EN: read address wraps RAM_WIDTH-1 -> 0 and any in-range start address is legal.
module sram_burst_reader #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RAM_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rsr_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [ADDR_WIDTH:0]   i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_cs,
    output logic [ADDR_WIDTH-1:0] o_address_r,
    output logic                  o_rd_en,
    input  logic [DATA_WIDTH-1:0] i_read_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready
);
    localparam int unsigned LEN_W = ADDR_WIDTH + 1;
    localparam int unsigned SUM_W = ADDR_WIDTH + 2;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CRD_W = PTR_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      issued_q, issued_d;
    logic                  rd_pend_q;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  busy_d, done_d, err_d, rd_en_d;
    logic [ADDR_WIDTH-1:0] address_r_d;
    logic                  push, pop, credit, cmd_legal;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
`ifdef SRAM_RD_WRAP_EN
        if (a == ADDR_WIDTH'(RAM_WIDTH - 1)) return '0;
`endif
        return a + ADDR_WIDTH'(1);
    endfunction

`ifdef SRAM_RD_WRAP_EN
    assign cmd_legal = (SUM_W'(i_start_addr) < SUM_W'(RAM_WIDTH)) &&
                       (SUM_W'(i_len) <= SUM_W'(RAM_WIDTH));
`else
    assign cmd_legal = (SUM_W'(i_start_addr) < SUM_W'(RAM_WIDTH)) &&
                       ((SUM_W'(i_start_addr) + SUM_W'(i_len)) <= SUM_W'(RAM_WIDTH));
`endif

    // A read in flight is either on the SRAM pins now or returning data this cycle.
    assign push    = rd_pend_q;
    assign pop     = o_valid && i_ready;
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    assign credit  = (CRD_W'(count_q) + CRD_W'(o_rd_en) + CRD_W'(rd_pend_q)) < CRD_W'(FIFO_DEPTH);
    assign o_data  = fifo_mem[rd_ptr_q];

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        len_d       = len_q;
        issued_d    = issued_q;
        rd_en_d     = 1'b0;
        address_r_d = o_address_r;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (i_len == '0) begin
                        done_d = 1'b1;
                    end else if (!cmd_legal) begin
                        err_d = 1'b1;
                    end else begin
                        len_d       = i_len;
                        rd_en_d     = 1'b1;
                        address_r_d = i_start_addr;
                        cur_addr_d  = next_addr(i_start_addr);
                        issued_d    = LEN_W'(1);
                        state_d     = (i_len == LEN_W'(1)) ? S_DRAIN : S_READ;
                    end
                end
            end
            S_READ: begin
                if (credit) begin
                    rd_en_d     = 1'b1;
                    address_r_d = cur_addr_q;
                    cur_addr_d  = next_addr(cur_addr_q);
                    issued_d    = issued_q + LEN_W'(1);
                    if (issued_d == len_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Finish in the first cycle with nothing outstanding and the FIFO empty.
                if (!o_rd_en && count_d == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rsr_n) begin
        if (!rsr_n) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            rd_pend_q   <= 1'b0;
            o_busy      <= 1'b0;
            o_cs        <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_rd_en     <= 1'b0;
            o_address_r <= '0;
            o_valid     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            rd_pend_q   <= o_rd_en;
            o_busy      <= busy_d;
            o_cs        <= busy_d;
            o_done      <= done_d;
            o_err       <= err_d;
            o_rd_en     <= rd_en_d;
            o_address_r <= address_r_d;
            o_valid     <= (count_d != '0);
        end
    end

    // Output FIFO; credit accounting keeps pushes away from a full buffer.
    always_ff @(posedge clk or negedge rsr_n) begin
        if (!rsr_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= i_read_data;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

endmodule
